// File: rtl/cpu_pkg.sv
// Shared fetch-path constants and the prefetch buffer entry type.
// Used by instr_fetch and if_fifo2.
package cpu_pkg;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam logic [AW-1:0] RESET_PC = 8'h00;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo2.sv
// Two-entry prefetch FIFO of {pc, word}.
// The head register drives decode directly; flush wins over push/pop.
module if_fifo2
    import cpu_pkg::*;
(
    input  logic         CLK,
    input  logic         RST_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t tail;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // An emptied head keeps its last value.
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front-end: PC, ROM address, prefetch buffer, redirects.
// Define IF_PERF_CNT_EN to build the fetch_cnt push counter.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int            AW       = cpu_pkg::AW,
    parameter int            DW       = cpu_pkg::DW,
    parameter logic [AW-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic          CLK,
    input  logic          RST_n,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          stall,
    input  logic          jmp_valid,
    input  logic [AW-1:0] jmp_addr,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [15:0]   fetch_cnt
);

    logic [AW-1:0] pc;
    logic [1:0]    count;
    logic          pop;
    logic          push;
    fetch_entry_t  head;
    fetch_entry_t  din;

    assign pop  = ir_valid && ir_ready;
    assign push = !jmp_valid && !stall && (count != 2'd2 || pop);

    assign rom_addr = pc;
    assign din      = '{pc: pc, word: rom_data};

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)         pc <= RESET_PC;
        else if (jmp_valid) pc <= jmp_addr;
        else if (push)      pc <= pc + AW'(1);
    end

    if_fifo2 u_fifo (
        .CLK   (CLK),
        .RST_n (RST_n),
        .push  (push),
        .pop   (pop),
        .flush (jmp_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );

    assign ir       = head.word;
    assign ir_pc    = head.pc;
    assign ir_valid = (count != 2'd0);

`ifdef IF_PERF_CNT_EN
    logic [15:0] cnt;

    // Counts every push, including words later flushed by a redirect.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)    cnt <= 16'd0;
        else if (push) cnt <= cnt + 16'd1;
    end

    assign fetch_cnt = cnt;
`else
    assign fetch_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed and random bench for instr_fetch against a queue-based model.
// The ROM is modelled combinationally inside the bench.
module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        stall = 1'b0;
    logic        jmp_valid = 1'b0;
    logic [7:0]  jmp_addr = 8'h00;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic [15:0] fetch_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] w;
    } ent_t;

    ent_t       q[$];
    logic [7:0] m_pc;
    int         m_cnt;

    instr_fetch dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .stall     (stall),
        .jmp_valid (jmp_valid),
        .jmp_addr  (jmp_addr),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .fetch_cnt (fetch_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] rom(input logic [7:0] a);
        case (a)
            8'h00:   rom = 16'h8000;
            8'h01:   rom = 16'hA07D;
            8'h02:   rom = 16'h8500;
            8'h03:   rom = 16'h0000;
            8'h04:   rom = 16'hA52D;
            8'h05:   rom = 16'h3180;
            8'h08:   rom = 16'h700B;
            default: rom = {a ^ 8'h5A, a};
        endcase
    endfunction

    assign rom_data = rom(rom_addr);

    function automatic logic [15:0] exp_cnt();
`ifdef IF_PERF_CNT_EN
        exp_cnt = 16'(m_cnt);
`else
        exp_cnt = 16'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".ir_valid"}, 32'(ir_valid), 32'(q.size() != 0));
        chk({tag, ".rom_addr"}, 32'(rom_addr), 32'(m_pc));
        chk({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(exp_cnt()));
        if (q.size() != 0) begin
            chk({tag, ".ir"}, 32'(ir), 32'(q[0].w));
            chk({tag, ".ir_pc"}, 32'(ir_pc), 32'(q[0].pc));
        end
    endtask

    task automatic step(input logic j, input logic [7:0] ja,
                        input logic st, input logic rdy);
        bit pop, full;
        jmp_valid = j;
        jmp_addr  = ja;
        stall     = st;
        ir_ready  = rdy;
        @(posedge CLK);
        pop  = (q.size() != 0) && rdy;
        full = (q.size() >= 2);
        if (j) begin
            q.delete();
            m_pc = ja;
        end else begin
            if (pop) void'(q.pop_front());
            if (!st && (!full || pop)) begin
                q.push_back('{pc: m_pc, w: rom(m_pc)});
                m_pc  = m_pc + 8'd1;
                m_cnt = (m_cnt + 1) & 16'hFFFF;
            end
        end
        #1;
        check_state("step");
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        q.delete();
        m_pc  = 8'h00;
        m_cnt = 0;
        #1;
        chk("rst.ir_valid", 32'(ir_valid), 32'd0);
        chk("rst.rom_addr", 32'(rom_addr), 32'h00);
        chk("rst.ir", 32'(ir), 32'h0);
        chk("rst.ir_pc", 32'(ir_pc), 32'h0);
        chk("rst.fetch_cnt", 32'(fetch_cnt), 32'h0);
        jmp_valid = 1'b0;
        stall     = 1'b0;
        ir_ready  = 1'b0;
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
    endtask

    initial begin
        logic [15:0] s1_ir[5];
        logic [15:0] s2_ir[3];
        logic [7:0]  p;
        s1_ir = '{16'h8000, 16'hA07D, 16'h8500, 16'h0000, 16'hA52D};
        s2_ir = '{16'h8000, 16'hA07D, 16'h8500};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            if (i < 5) begin
                chk("s1.ir", 32'(ir), 32'(s1_ir[i]));
                chk("s1.ir_pc", 32'(ir_pc), 32'(i));
            end
        end
`ifdef IF_PERF_CNT_EN
        chk("s1.cnt10", 32'(fetch_cnt), 32'd10);
`else
        chk("s1.cnt0", 32'(fetch_cnt), 32'd0);
`endif

        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("s2.rom_addr", 32'(rom_addr), 32'h02);
        for (int i = 0; i < 3; i++) begin
            chk("s2.ir", 32'(ir), 32'(s2_ir[i]));
            chk("s2.valid", 32'(ir_valid), 32'd1);
            step(1'b0, 8'h00, 1'b0, 1'b1);
        end

        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s3.pre_pc", 32'(ir_pc), 32'h02);
        step(1'b1, 8'h08, 1'b0, 1'b1);
        chk("s3.bubble", 32'(ir_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s3.ir", 32'(ir), 32'h700B);
        chk("s3.ir_pc", 32'(ir_pc), 32'h08);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s3.next_pc", 32'(ir_pc), 32'h09);

        step(1'b1, 8'hFE, 1'b0, 1'b1);
        chk("s4.bubble", 32'(ir_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s4.pc_fe", 32'(ir_pc), 32'hFE);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s4.pc_ff", 32'(ir_pc), 32'hFF);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s4.pc_00", 32'(ir_pc), 32'h00);
        chk("s4.ir_00", 32'(ir), 32'h8000);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s4.pc_01", 32'(ir_pc), 32'h01);

        p = m_pc;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("s5.empty", 32'(ir_valid), 32'd0);
        chk("s5.pc_hold", 32'(rom_addr), 32'(p));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s5.resume", 32'(ir_pc), 32'(p));

        p = m_pc;
        step(1'b1, p, 1'b0, 1'b1);
        chk("s6.self_bubble", 32'(ir_valid), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("s6.self_pc", 32'(ir_pc), 32'(p));

        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("s7.full", 32'(q.size()), 32'd2);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            logic       j;
            logic [7:0] ja;
            j  = ($urandom_range(0, 7) == 0);
            ja = ($urandom_range(0, 3) == 0) ? m_pc : 8'($urandom);
            step(j, ja, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch front-end; the reader side of the 8-bit-address / 16-bit-word combinational program ROM (lpm_rom).
- Owns the program counter and drives the ROM address.
- Captures each returned word into a 2-entry prefetch buffer tagged with its PC.
- Hands instructions to decode over a valid/ready handshake; accepts jump redirects from execute.

Parameters:
- AW, 8, program address width (ROM address width)
- DW, 16, instruction word width
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST_n  in  1  asynchronous active-low reset
- rom_addr  out  AW  address to ROM; always equals pc
- rom_data  in  DW  combinational ROM read data for rom_addr, same cycle
- stall  in  1  freeze fetch: no push, pc holds
- jmp_valid  in  1  redirect request
- jmp_addr  in  AW  redirect target
- ir  out  DW  instruction at buffer head
- ir_pc  out  AW  address of ir
- ir_valid  out  1  buffer non-empty
- ir_ready  in  1  decode consumes head when ir_valid&&ir_ready
- fetch_cnt  out  16  count of words pushed (see Optional Feature)

Behaviour:
- Reset (async, RST_n=0):
  - pc=RESET_PC; buffer empty; ir_valid=0; ir=0; ir_pc=0; fetch_cnt=0.
  - rom_addr follows pc combinationally, so it reads RESET_PC during reset.
- pop = ir_valid && ir_ready.
- push = !jmp_valid && !stall && (count<2 || pop).
- Per rising edge, priority order:
  1. jmp_valid=1: buffer flushed (count=0), pc<=jmp_addr, no push. Any simultaneous pop is discarded and stall is ignored.
  2. Otherwise: pop removes the head; push appends {pc, rom_data} and pc<=pc+1. Push and pop may occur on the same edge.
- Buffer is a 2-entry FIFO of {AW pc, DW word}; ir and ir_pc present the head. When empty, ir and ir_pc hold their last value and are don't-care.
- Latency: word at address A is on ir one cycle after the edge on which rom_addr=A with push=1.
  - First instruction after reset release: ir_valid=1 after the 1st edge.
  - Redirect bubble: ir_valid=0 for exactly one cycle after the redirect edge, then ir=word@jmp_addr.
- Full (count=2) with no pop: no push, pc holds, rom_addr stable.
- Full with pop: push allowed on the same edge, so throughput is 1 instr/cycle.
- Empty with ir_ready=1: no pop; ir_ready is ignored.
- pc wrap: 8'hFF+1 -> 8'h00, no flag.
- jmp_addr=pc: still flushes and refetches.
- Reset mid-operation clears all state immediately regardless of the handshake.

Optional Feature:
- Macro IF_PERF_CNT_EN.
  - Defined: fetch_cnt increments by 1 on every push, wraps at 16'hFFFF->0, and is cleared only by reset. Flushed words are still counted.
  - Undefined: fetch_cnt is tied to 0 and no counter register is built.

Decomposition:
- Shared package cpu_pkg:
  - AW/DW constants
  - RESET_PC default
  - typedef fetch_entry_t {pc, word}
- One natural sub-module: if_fifo2 (2-entry FIFO with push, pop, flush, count, head outputs).
- PC, redirect and counter logic stay in instr_fetch.

Test Plan:
- Bench ROM model for all cases: 0:8000, 1:A07D, 2:8500, 3:0000, 4:A52D, 5:3180, 8:700B.
- Reset release with ir_ready=1 held -> ir/ir_pc sequence 8000/00, A07D/01, 8500/02, 0000/03, A52D/04 on consecutive cycles; ir_valid=1 from cycle 1.
- ir_ready=0 for 4 cycles after reset -> buffer holds {00,01}, rom_addr stays 02; on ready, 8000, A07D, 8500 with no gap.
- jmp_valid=1, jmp_addr=08 while ir_pc=02 and ir_ready=1 -> one cycle ir_valid=0, then ir=700B, ir_pc=08, then ir_pc=09.
- Redirect to FE with ir_ready=1 -> ir_pc FE, FF, 00, 01 (wrap); ir at 00 = 8000.
- stall=1 for 3 cycles with ir_ready=1 -> buffer drains to empty, pc unchanged; on stall=0, fetch resumes at the held pc.
- Assert RST_n=0 mid-stream while full -> ir_valid=0 and rom_addr=00 immediately, before the next edge.
- With IF_PERF_CNT_EN: after 10 pushes, fetch_cnt=10. Without the macro: fetch_cnt=0 throughout.
